// File: rtl/proc_pkg.sv
// Shared types and IR field helpers for the parametrised accumulator core.
// Field positions are functions so every width follows DATA_W/RA_W.
package proc_pkg;

   typedef enum logic [3:0] {
      OP_LOAD  = 4'd0,
      OP_MOV   = 4'd1,
      OP_ADD   = 4'd2,
      OP_SUB   = 4'd3,
      OP_AND   = 4'd4,
      OP_OR    = 4'd5,
      OP_XOR   = 4'd6,
      OP_NOT   = 4'd7,
      OP_SHL   = 4'd8,
      OP_SHR   = 4'd9,
      OP_NOP_A = 4'd10,
      OP_NOP_B = 4'd11,
      OP_NOP_C = 4'd12,
      OP_NOP_D = 4'd13,
      OP_NOP_E = 4'd14,
      OP_NOP_F = 4'd15
   } opcode_e;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_T1    = 2'd1,
      S_T2    = 2'd2,
      S_T3    = 2'd3
   } state_e;

   function automatic int op_msb(input int data_w);
      return data_w - 1;
   endfunction

   function automatic int rx_lsb(input int ra_w);
      return ra_w;
   endfunction

   function automatic int ry_lsb(input int ra_w);
      return ra_w - ra_w;
   endfunction

endpackage

// File: rtl/proc_regfile.sv
// General register file: one write port, operand and peek read ports.
// Reads are combinational, so a same-cycle write is seen only next cycle.
module proc_regfile
   import proc_pkg::*;
#(
   parameter  int DATA_W = 10,
   parameter  int NREG   = 4,
   localparam int RA_W   = $clog2(NREG)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [RA_W-1:0]   waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [RA_W-1:0]   raddr_i,
   output logic [DATA_W-1:0] rdata_o,
   input  logic [RA_W-1:0]   paddr_i,
   output logic [DATA_W-1:0] pdata_o
);

   logic [DATA_W-1:0] regs_q [NREG];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = regs_q[raddr_i];
   assign pdata_o = regs_q[paddr_i];

endmodule

// File: rtl/proc_core_param.sv
// Multi-cycle accumulator core: FETCH/T1..T3 sequencer, A/G ALU, flags.
// Every update is gated by adv (RUN every cycle, STEP on a step edge).
module proc_core_param
   import proc_pkg::*;
#(
   parameter  int DATA_W = 10,
   parameter  int NREG   = 4,
   localparam int RA_W   = $clog2(NREG)
) (
   input  logic              CLKb,
   input  logic              RSTn,
   input  logic [DATA_W-1:0] D,
   input  logic              d_valid,
   output logic              d_ready,
   input  logic              run_mode,
   input  logic              step,
   input  logic [RA_W-1:0]   peek_addr,
   output logic [DATA_W-1:0] peek_data,
   output logic [DATA_W-1:0] bus,
   output logic [1:0]        tstep,
   output logic              flag_z,
   output logic              flag_c,
   output logic              done
);

   localparam int OP_MSB = op_msb(DATA_W);
   localparam int RX_LSB = rx_lsb(RA_W);
   localparam int RY_LSB = ry_lsb(RA_W);

   state_e            state_q, state_d;
   opcode_e           op_q, op_d;
   logic [RA_W-1:0]   rx_q, rx_d, ry_q, ry_d;
   logic [DATA_W-1:0] a_q, a_d, g_q, g_d;
   logic              z_q, z_d, c_q, c_d;
   logic              step_q;

   logic              adv, xfer, rdy, done_c;
   logic [DATA_W-1:0] bus_c;
   logic              we;
   logic [RA_W-1:0]   wa, ra;
   logic [DATA_W-1:0] wd, rd;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] alu_r;
   logic              alu_c;

   assign adv  = run_mode | (step & ~step_q);
   assign xfer = d_valid & rdy;

   // T1 of an ALU op latches R[Rx] into A; every other read uses Ry
   assign ra = (state_q == S_T1 && op_q != OP_MOV) ? rx_q : ry_q;

   proc_regfile #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_rf (
      .clk_i   (CLKb),
      .rst_ni  (RSTn),
      .we_i    (we),
      .waddr_i (wa),
      .wdata_i (wd),
      .raddr_i (ra),
      .rdata_o (rd),
      .paddr_i (peek_addr),
      .pdata_o (peek_data)
   );

   always_comb begin
      sum   = '0;
      alu_r = '0;
      alu_c = 1'b0;
      unique case (op_q)
         OP_ADD: begin
            sum   = {1'b0, a_q} + {1'b0, rd};
            alu_r = sum[DATA_W-1:0];
            alu_c = sum[DATA_W];
         end
         OP_SUB: begin
            sum   = {1'b0, a_q} - {1'b0, rd};
            alu_r = sum[DATA_W-1:0];
            alu_c = sum[DATA_W];
         end
         OP_AND: alu_r = a_q & rd;
         OP_OR:  alu_r = a_q | rd;
         OP_XOR: alu_r = a_q ^ rd;
         OP_NOT: alu_r = ~a_q;
         OP_SHL: begin
            alu_r = {a_q[DATA_W-2:0], 1'b0};
            alu_c = a_q[DATA_W-1];
         end
         OP_SHR: begin
            alu_r = {1'b0, a_q[DATA_W-1:1]};
            alu_c = a_q[0];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rx_d    = rx_q;
      ry_d    = ry_q;
      a_d     = a_q;
      g_d     = g_q;
      z_d     = z_q;
      c_d     = c_q;
      rdy     = 1'b0;
      done_c  = 1'b0;
      bus_c   = '0;
      we      = 1'b0;
      wa      = rx_q;
      wd      = g_q;
      if (adv) begin
         unique case (state_q)
            S_FETCH: begin
               rdy = 1'b1;
               if (xfer) begin
                  op_d    = opcode_e'(D[OP_MSB -: 4]);
                  rx_d    = D[RX_LSB +: RA_W];
                  ry_d    = D[RY_LSB +: RA_W];
                  bus_c   = D;
                  state_d = S_T1;
               end
            end
            S_T1: begin
               unique case (op_q)
                  OP_LOAD: begin
                     rdy = 1'b1;
                     if (xfer) begin
                        we      = 1'b1;
                        wd      = D;
                        bus_c   = D;
                        done_c  = 1'b1;
                        state_d = S_FETCH;
                     end
                  end
                  OP_MOV: begin
                     we      = 1'b1;
                     wd      = rd;
                     bus_c   = rd;
                     done_c  = 1'b1;
                     state_d = S_FETCH;
                  end
                  OP_ADD, OP_SUB, OP_AND, OP_OR,
                  OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
                     a_d     = rd;
                     bus_c   = rd;
                     state_d = S_T2;
                  end
                  default: begin
                     done_c  = 1'b1;
                     state_d = S_FETCH;
                  end
               endcase
            end
            S_T2: begin
               bus_c   = rd;
               g_d     = alu_r;
               z_d     = (alu_r == '0);
               c_d     = alu_c;
               state_d = S_T3;
            end
            S_T3: begin
               we      = 1'b1;
               wd      = g_q;
               bus_c   = g_q;
               done_c  = 1'b1;
               state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge CLKb or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= S_FETCH;
         op_q    <= OP_LOAD;
         rx_q    <= '0;
         ry_q    <= '0;
         a_q     <= '0;
         g_q     <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rx_q    <= rx_d;
         ry_q    <= ry_d;
         a_q     <= a_d;
         g_q     <= g_d;
         z_q     <= z_d;
         c_q     <= c_d;
         step_q  <= step;
      end
   end

   // Handshake and strobes stay quiet while reset is held
   assign d_ready = RSTn & rdy;
   assign done    = RSTn & done_c;
   assign bus     = RSTn ? bus_c : '0;
   assign tstep   = state_q;
   assign flag_z  = z_q;
   assign flag_c  = c_q;

endmodule

// File: tb/tb_proc_core_param.sv
// Directed + random checks of proc_core_param against an arithmetic model.
module tb_proc_core_param;

   logic       CLKb;
   logic       RSTn;
   logic [9:0] D;
   logic       d_valid;
   logic       d_ready;
   logic       run_mode;
   logic       step;
   logic [1:0] peek_addr;
   logic [9:0] peek_data;
   logic [9:0] bus;
   logic [1:0] tstep;
   logic       flag_z;
   logic       flag_c;
   logic       done;

   int nerr = 0;
   int nchk = 0;

   int mr [4];
   bit mz, mc;

   proc_core_param dut (
      .CLKb      (CLKb),
      .RSTn      (RSTn),
      .D         (D),
      .d_valid   (d_valid),
      .d_ready   (d_ready),
      .run_mode  (run_mode),
      .step      (step),
      .peek_addr (peek_addr),
      .peek_data (peek_data),
      .bus       (bus),
      .tstep     (tstep),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .done      (done)
   );

   initial begin
      CLKb = 1'b0;
      forever #10 CLKb = ~CLKb;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mr[i] = 0;
      mz = 0;
      mc = 0;
   endtask

   function automatic int exp_lat(input logic [9:0] ins);
      int op;
      op = int'(ins[9:6]);
      return (op >= 2 && op <= 9) ? 4 : 2;
   endfunction

   // Reference semantics written directly from the instruction set rules
   task automatic model_exec(input logic [9:0] ins, input logic [9:0] imm);
      int op, rx, ry, a, b, res;
      bit alu;
      op  = int'(ins[9:6]);
      rx  = int'(ins[3:2]);
      ry  = int'(ins[1:0]);
      a   = mr[rx];
      b   = mr[ry];
      alu = 1;
      res = 0;
      case (op)
         0: begin mr[rx] = int'(imm); alu = 0; end
         1: begin mr[rx] = b; alu = 0; end
         2: begin res = a + b; mc = (res > 1023); end
         3: begin res = a - b; mc = (a < b); end
         4: begin res = a & b; mc = 0; end
         5: begin res = a | b; mc = 0; end
         6: begin res = a ^ b; mc = 0; end
         7: begin res = 1023 - a; mc = 0; end
         8: begin res = a * 2; mc = (a >= 512); end
         9: begin res = a / 2; mc = ((a % 2) == 1); end
         default: alu = 0;
      endcase
      if (alu) begin
         res = res & 1023;
         mr[rx] = res;
         mz = (res == 0);
      end
   endtask

   task automatic check_state(input string tag);
      for (int i = 0; i < 4; i++) begin
         peek_addr = 2'(i);
         #1;
         chk($sformatf("%s_R%0d", tag, i), 32'(peek_data), mr[i]);
      end
      chk({tag, "_Z"}, 32'(flag_z), 32'(mz));
      chk({tag, "_C"}, 32'(flag_c), 32'(mc));
   endtask

   task automatic peek(input int i, output logic [9:0] v);
      peek_addr = 2'(i);
      #1;
      v = peek_data;
   endtask

   task automatic run_instr(input logic [9:0] ins, input logic [9:0] imm);
      int cyc, lat;
      bit fin, fet;
      cyc = 0;
      lat = 0;
      fin = 0;
      @(negedge CLKb);
      D = ins;
      d_valid = 1'b1;
      while (!fin && cyc < 16) begin
         #1;
         cyc++;
         fet = (tstep == 2'd0) && d_ready;
         if (cyc == 1) chk("fetch_bus", 32'(bus), int'(ins));
         if (done) begin
            fin = 1;
            lat = cyc;
         end
         @(negedge CLKb);
         if (fet) begin
            D = imm;
            d_valid = (ins[9:6] == 4'd0);
         end
      end
      d_valid = 1'b0;
      D = '0;
      chk($sformatf("latency_%03h", ins), lat, exp_lat(ins));
      model_exec(ins, imm);
      check_state($sformatf("ins_%03h", ins));
   endtask

   initial begin
      logic [9:0] v;
      logic [9:0] ins, imm;
      RSTn = 1'b0;
      run_mode = 1'b1;
      step = 1'b0;
      D = '0;
      d_valid = 1'b0;
      peek_addr = '0;
      model_reset();

      #3;
      chk("rst_rdy", 32'(d_ready), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ts", 32'(tstep), 0);
      repeat (2) @(negedge CLKb);
      RSTn = 1'b1;
      #1;
      chk("t1_rdy", 32'(d_ready), 1);
      chk("t1_bus", 32'(bus), 0);
      chk("t1_ts", 32'(tstep), 0);
      chk("t1_done", 32'(done), 0);
      check_state("t1");

      run_instr(10'h004, 10'h155);
      peek(1, v);
      chk("t2_R1", 32'(v), 32'h155);

      run_instr(10'h004, 10'h3FF);
      run_instr(10'h008, 10'h001);
      run_instr(10'h086, 10'h000);
      chk("t3_Z", 32'(flag_z), 1);
      chk("t3_C", 32'(flag_c), 1);

      run_instr(10'h000, 10'h002);
      run_instr(10'h00C, 10'h003);
      run_instr(10'h0C3, 10'h000);
      run_instr(10'h240, 10'h000);
      peek(0, v);
      chk("t4_R0", 32'(v), 32'h1FF);
      chk("t4_C", 32'(flag_c), 1);

      run_instr(10'h004, 10'h005);
      run_instr(10'h008, 10'h007);
      @(negedge CLKb);
      run_mode = 1'b0;
      step = 1'b0;
      D = 10'h086;
      d_valid = 1'b1;
      repeat (20) @(negedge CLKb);
      #1;
      chk("t5_hold_ts", 32'(tstep), 0);
      chk("t5_hold_rdy", 32'(d_ready), 0);
      chk("t5_hold_done", 32'(done), 0);
      check_state("t5_hold");
      for (int e = 0; e < 4; e++) begin
         @(negedge CLKb);
         step = 1'b1;
         #1;
         chk($sformatf("t5_done_%0d", e), 32'(done), (e == 3) ? 1 : 0);
         @(negedge CLKb);
         if (e == 0) begin
            d_valid = 1'b0;
            D = '0;
         end
         #1;
         chk($sformatf("t5_ts_%0d", e), 32'(tstep), (e + 1) % 4);
         chk($sformatf("t5_nodone_%0d", e), 32'(done), 0);
         @(negedge CLKb);
         step = 1'b0;
         repeat (2) @(negedge CLKb);
         #1;
         chk($sformatf("t5_tshold_%0d", e), 32'(tstep), (e + 1) % 4);
      end
      model_exec(10'h086, 10'h000);
      check_state("t5_end");
      run_mode = 1'b1;

      run_instr(10'h3C0, 10'h000);

      for (int n = 0; n < 40; n++) begin
         ins = 10'(($urandom_range(0, 15) << 6) | $urandom_range(0, 63));
         imm = 10'($urandom_range(0, 1023));
         run_instr(ins, imm);
      end

      run_instr(10'h00C, 10'h2A5);
      @(negedge CLKb);
      D = 10'h086;
      d_valid = 1'b1;
      @(negedge CLKb);
      d_valid = 1'b0;
      D = '0;
      @(negedge CLKb);
      #1;
      chk("t6_at_t2", 32'(tstep), 2);
      RSTn = 1'b0;
      #1;
      chk("t6_rst_ts", 32'(tstep), 0);
      chk("t6_rst_rdy", 32'(d_ready), 0);
      chk("t6_rst_bus", 32'(bus), 0);
      model_reset();
      check_state("t6_rst");
      @(negedge CLKb);
      RSTn = 1'b1;
      run_instr(10'h004, 10'h155);
      run_instr(10'h086, 10'h000);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
